// File: rtl/alu_md_pkg.sv
// alu_md_pkg: opcodes, state encoding and shift-width helper for alu_md
package alu_md_pkg;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
  function automatic int shw_of(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter: shift-add multiply / restoring divide engine; ALU_MD_EARLY_TERM_EN ends MULTU once remaining multiplier bits are zero
module alu_md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_n;
  logic [2*WIDTH-1:0] acc, acc_n, opnd;
  logic [WIDTH-1:0] mplier;
  logic [SHW-1:0] cnt;
  logic [WIDTH:0] trial, diff;
  logic last, mul_last, fin;
  assign last = cnt == SHW'(WIDTH - 1);
`ifdef ALU_MD_EARLY_TERM_EN
  assign mul_last = last || mplier[WIDTH-1:1] == '0;
`else
  assign mul_last = last;
`endif
  assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = trial - {1'b0, opnd[WIDTH-1:0]};
  assign fin = state == ST_MUL ? mul_last : state == ST_DIV && last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == ST_IDLE ? (start_mul ? ST_MUL : start_div ? ST_DIV : ST_IDLE)
            : (flush || fin) ? ST_IDLE : state;
  always_comb begin
    busy = state != ST_IDLE;
    done = fin && !flush;
  end
  always_comb
    acc_n = state == ST_MUL ? acc + (mplier[0] ? opnd : '0)
          : {diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]};
  assign hi = acc_n[2*WIDTH-1:WIDTH];
  assign lo = acc_n[WIDTH-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      opnd <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (start_mul) begin
      acc <= '0;
      opnd <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt <= '0;
    end else if (start_div) begin
      acc <= {{WIDTH{1'b0}}, a};
      opnd <= {{WIDTH{1'b0}}, b};
      cnt <= '0;
    end else if (busy) begin
      acc <= acc_n;
      opnd <= state == ST_MUL ? opnd << 1 : opnd;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_md.sv
// alu_md: registered ALU with iterative MULTU/DIVU and HI/LO; ALU_MD_EARLY_TERM_EN (in alu_md_iter) shortens MULTU
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  logic accept, start_mul, start_div, busy, done, ovf_c;
  logic [WIDTH-1:0] hi, lo, it_hi, it_lo, sum, dif, res_c;
  assign accept = in_valid && in_ready && !flush;
  assign start_mul = accept && ctl == OP_MULTU;
  assign start_div = accept && ctl == OP_DIVU && b != '0;
  assign in_ready = !busy;
  assign sum = a + b;
  assign dif = a - b;
  alu_md_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk(clk), .rst(rst), .start_mul(start_mul), .start_div(start_div), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .hi(it_hi), .lo(it_lo)
  );
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (ctl)
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_ADD: begin
        res_c = sum;
        ovf_c = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB: begin
        res_c = dif;
        ovf_c = a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1];
      end
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SRL:  res_c = b >> shamt;
      OP_SLL:  res_c = b << shamt;
      OP_SRA:  res_c = $signed(b) >>> shamt;
      OP_XOR:  res_c = a ^ b;
      OP_NOR:  res_c = ~(a | b);
      OP_DIVU: res_c = '1;
      OP_MFHI: res_c = hi;
      OP_MFLO: res_c = lo;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      result <= '0;
      ovf <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      out_valid <= 1'b1;
      result <= it_lo;
      ovf <= 1'b0;
      hi <= it_hi;
      lo <= it_lo;
    end else if (accept && !start_mul && !start_div) begin
      out_valid <= 1'b1;
      result <= res_c;
      ovf <= ovf_c;
      if (ctl == OP_DIVU) begin
        hi <= a;
        lo <= '1;
      end
    end else out_valid <= 1'b0;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed self-checking bench for alu_md
module tb_alu_md;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0;
  logic in_ready, out_valid, ovf;
  logic [3:0] ctl = 4'b0;
  logic [31:0] a = '0, b = '0, result;
  logic [4:0] shamt = '0;
  int checks = 0, failures = 0, edges;
  logic ready_low;
  alu_md dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctl(ctl),
    .a(a), .b(b), .shamt(shamt), .flush(flush), .out_valid(out_valid),
    .result(result), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
    ctl = c;
    a = x;
    b = y;
    shamt = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic run_multi(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, output int n, output logic rl);
    issue(c, x, y, 5'd0);
    n = 1;
    rl = 1'b1;
    while (!out_valid && n < 100) begin
      if (in_ready) rl = 1'b0;
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic op(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                    input logic [4:0] s, input logic [31:0] er, input logic eo);
    issue(c, x, y, s);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, result, er);
    check({tag, "_ovf"}, ovf, eo);
  endtask
  initial begin
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1);
    op("sub", 4'b0110, 32'd5, 32'd7, 0, 32'hFFFFFFFE, 0);
    op("slt", 4'b0111, 32'h80000000, 32'h7FFFFFFF, 0, 32'h1, 0);
    op("slt_ge", 4'b0111, 32'h7FFFFFFF, 32'h80000000, 0, 32'h0, 0);
    op("sra", 4'b1001, 32'h0, 32'h80000000, 4, 32'hF8000000, 0);
    op("srl", 4'b0011, 32'h0, 32'h80000000, 4, 32'h08000000, 0);
    op("sll", 4'b1000, 32'h0, 32'h1, 31, 32'h80000000, 0);
    op("and", 4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, 0, 32'hF000_1200, 0);
    op("or", 4'b0001, 32'hF0F0_1234, 32'hFF00_FF00, 0, 32'hFFF0_FF34, 0);
    op("xor", 4'b1010, 32'hF0F0_1234, 32'hFF00_FF00, 0, 32'h0FF0_ED34, 0);
    op("nor", 4'b1011, 32'hF0F0_1234, 32'hFF00_FF00, 0, 32'h000F_00CB, 0);
    op("rsv", 4'b0100, 32'h7FFFFFFF, 32'h1, 0, 32'h0, 0);
    op("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 1);
    run_multi(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, edges, ready_low);
    check("mul_lat", edges, 33);
    check("mul_ready_low", ready_low, 1);
    check("mul_lo", result, 32'h1);
    check("mul_ready_after", in_ready, 1);
    op("mfhi_mul", 4'b1110, 0, 0, 0, 32'hFFFFFFFE, 0);
    op("mflo_mul", 4'b1111, 0, 0, 0, 32'h1, 0);
    run_multi(4'b1101, 32'd100, 32'd7, edges, ready_low);
    check("div_lat", edges, 33);
    check("div_q", result, 14);
    op("mfhi_div", 4'b1110, 0, 0, 0, 32'd2, 0);
    op("div0", 4'b1101, 32'd9, 32'd0, 0, 32'hFFFFFFFF, 0);
    check("div0_ready", in_ready, 1);
    op("mfhi_div0", 4'b1110, 0, 0, 0, 32'd9, 0);
    run_multi(4'b1100, 32'd3, 32'd5, edges, ready_low);
`ifdef ALU_MD_EARLY_TERM_EN
    check("mul35_lat", edges, 4);
`else
    check("mul35_lat", edges, 33);
`endif
    check("mul35_lo", result, 15);
    op("mfhi_35", 4'b1110, 0, 0, 0, 32'd0, 0);
    op("div0b", 4'b1101, 32'd9, 32'd0, 0, 32'hFFFFFFFF, 0);
    issue(4'b1100, 32'd3, 32'hFFFF0000, 0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("flush_busy", in_ready, 0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    @(posedge clk);
    #1 check("flush_valid2", out_valid, 0);
    op("mflo_flush", 4'b1111, 0, 0, 0, 32'hFFFFFFFF, 0);
    op("mfhi_flush", 4'b1110, 0, 0, 0, 32'd9, 0);
    flush = 1'b1;
    issue(4'b0010, 32'd1, 32'd1, 0);
    flush = 1'b0;
    check("idle_flush_valid", out_valid, 0);
    check("idle_flush_result", result, 32'd9);
    issue(4'b1101, 32'd100, 32'd7, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("arst_result", result, 0);
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    op("mflo_rst", 4'b1111, 0, 0, 0, 32'd0, 0);
    op("mfhi_rst", 4'b1110, 0, 0, 0, 32'd0, 0);
    @(posedge clk);
    #1 check("idle_valid", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
